// File: rtl/ex_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// ex_pipeline_ctrl
//
// Purpose:
//   Stall / flush / sequencing controller for the execution stage of a
//   5-stage ALU pipeline. Each cycle it decides whether to freeze the front
//   of the pipe, inject a bubble into ID/EX, or flush IF/ID. It also holds
//   the EX stage for a fixed number of cycles while an iterative mul/div
//   finishes, and keeps a saturating count of cycles in which the PC stalled.
//
// Ports:
//   clk                 rising-edge clock
//   rst                 asynchronous reset, active-high
//   id_rs1_i/id_rs2_i   source registers of the instruction in ID
//   id_use_rs1_i/_rs2_i ID instruction actually reads rs1 / rs2
//   ex_memread_i        instruction in EX is a load
//   ex_rd_i             destination register of the instruction in EX
//   ex_multicycle_i     instruction in EX is a multi-cycle op
//   ex_branch_taken_i   branch resolved taken in EX
//   mem_stall_req_i     data-memory stall request
//   pc_en_o             PC update enable
//   ifid_en_o           IF/ID register enable
//   ifid_flush_o        clear IF/ID to NOP
//   idex_bubble_o       load NOP into ID/EX
//   ex_hold_o           freeze the EX/MEM registers
//   mc_busy_o           multi-cycle sequencer active (registered)
//   mc_done_o           one-cycle pulse in the release cycle of a multi-cycle op
//   stall_cnt_o         saturating count of cycles with pc_en_o = 0
// ---------------------------------------------------------------------------
module ex_pipeline_ctrl #(
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_multicycle_i,
    input  logic             ex_branch_taken_i,
    input  logic             mem_stall_req_i,
    output logic             pc_en_o,
    output logic             ifid_en_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             ex_hold_o,
    output logic             mc_busy_o,
    output logic             mc_done_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic {
        RUN = 1'b0,
        MC  = 1'b1
    } state_e;

    // The start cycle is already one hold cycle, so the down-counter is
    // loaded with two less than the total EX occupancy.
    localparam logic [3:0] MC_INIT = 4'(MC_LAT - 2);

    state_e             state_q, state_d;
    logic [3:0]         mc_cnt_q, mc_cnt_d;
    logic               mc_busy_q;
    logic [CNT_W-1:0]   stall_cnt_q;
    logic               load_use;

    // A load in EX whose destination feeds an operand the ID instruction
    // really reads. Register x0 never creates a dependency.
    assign load_use = ex_memread_i && (ex_rd_i != 5'd0) &&
                      ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                       (id_use_rs2_i && (id_rs2_i == ex_rd_i)));

    // Next-state and output decode. The if/else chain encodes the priority
    // order: memory stall, then multi-cycle hold, then branch flush, then
    // load-use. Branches are only seen once EX is no longer held.
    always_comb begin
        state_d       = state_q;
        mc_cnt_d      = mc_cnt_q;
        pc_en_o       = 1'b1;
        ifid_en_o     = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        ex_hold_o     = 1'b0;
        mc_done_o     = 1'b0;

        if (mem_stall_req_i) begin
            ex_hold_o = 1'b1;
            pc_en_o   = 1'b0;
            ifid_en_o = 1'b0;
        end else if (state_q == RUN && ex_multicycle_i) begin
            ex_hold_o = 1'b1;
            pc_en_o   = 1'b0;
            ifid_en_o = 1'b0;
            state_d   = MC;
            mc_cnt_d  = MC_INIT;
        end else if (state_q == MC && mc_cnt_q != 4'd0) begin
            ex_hold_o = 1'b1;
            pc_en_o   = 1'b0;
            ifid_en_o = 1'b0;
            mc_cnt_d  = mc_cnt_q - 4'd1;
        end else begin
            // Release cycle: EX/MEM captures the result on this edge, and the
            // front of the pipe is free to react to branch / load-use events.
            if (state_q == MC) begin
                mc_done_o = 1'b1;
                state_d   = RUN;
            end
            if (ex_branch_taken_i) begin
                ifid_flush_o  = 1'b1;
                idex_bubble_o = 1'b1;
            end else if (load_use) begin
                pc_en_o       = 1'b0;
                ifid_en_o     = 1'b0;
                idex_bubble_o = 1'b1;
            end
        end
    end

    // State, sequencer counter, busy flag and the performance counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            mc_cnt_q    <= 4'd0;
            mc_busy_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mc_cnt_q  <= mc_cnt_d;
            mc_busy_q <= (state_d == MC);
            if (!pc_en_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign mc_busy_o   = mc_busy_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: doc/ex_pipeline_ctrl.md
Name: ex_pipeline_ctrl

Overview:
- Stall/flush/sequencing controller for the 5-stage ALU pipeline around the execution stage.
- Decides each cycle whether to freeze the pipe, insert a bubble into ID/EX, or flush IF/ID.
- Sequences multi-cycle EX operations (iterative mul/div) by holding the EX stage for a fixed count; `ex_hold` drives the EX stage's freeze input directly.
- Keeps a saturating stall-cycle counter for performance measurement.

Parameters:
- MC_LAT, 4: total EX-occupancy cycles of a multi-cycle op; legal range 2..16.
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- id_rs1  in  5  source register 1 of the instruction in ID.
- id_rs2  in  5  source register 2 of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_memread  in  1  instruction in EX is a load.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_multicycle  in  1  instruction in EX is a multi-cycle op.
- ex_branch_taken  in  1  branch resolved taken in EX.
- mem_stall_req  in  1  data-memory stall request.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID register enable.
- ifid_flush  out  1  clear IF/ID to NOP.
- idex_bubble  out  1  load NOP into ID/EX.
- ex_hold  out  1  freeze the EX/MEM registers (EX-stage stall input).
- mc_busy  out  1  multi-cycle sequencer active (registered).
- mc_done  out  1  one-cycle pulse in the release cycle of a multi-cycle op.
- stall_cnt  out  CNT_W  cycles with pc_en=0, saturating.

Behaviour:
- State register: RUN / MC. Counter: mc_cnt, 4 bits.
- All outputs except mc_busy and stall_cnt are combinational from state, mc_cnt and inputs.
- Reset (async, any time including mid-MC):
  - state=RUN, mc_cnt=0, stall_cnt=0, mc_busy=0.
  - Combinational outputs then follow the RUN equations.
  - With all inputs 0: pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0, ex_hold=0, mc_done=0.
- Priority, highest first: mem stall > multi-cycle hold > branch flush > load-use.
- mem_stall_req=1, any state:
  - ex_hold=1, pc_en=0, ifid_en=0, idex_bubble=0, ifid_flush=0, mc_done=0.
  - State and mc_cnt frozen.
- RUN with ex_multicycle=1 and no mem stall:
  - ex_hold=1, pc_en=0, ifid_en=0.
  - Next state MC, mc_cnt <= MC_LAT-2.
- MC with no mem stall:
  - mc_cnt!=0: ex_hold=1, pc_en=0, ifid_en=0; mc_cnt decrements.
  - mc_cnt==0: ex_hold=0, mc_done=1, next state RUN; EX/MEM captures the result this edge.
  - Total ex_hold cycles per op = MC_LAT-1, excluding mem stall cycles.
- mc_busy <= 1 on entry to MC, 0 on return to RUN. Asserted from the cycle after the start cycle through the release cycle.
- Branch flush: ex_branch_taken=1 while EX is not held:
  - ifid_flush=1, idex_bubble=1, pc_en=1 (PC loads the target).
  - Load-use detection is suppressed in the same cycle.
  - ex_branch_taken is ignored while ex_hold=1.
- Load-use hazard:
  - Condition: ex_memread=1, ex_rd!=0, and (id_use_rs1 && id_rs1==ex_rd || id_use_rs2 && id_rs2==ex_rd).
  - When the condition holds with no higher event: pc_en=0, ifid_en=0, idex_bubble=1, ex_hold=0.
  - Lasts exactly one cycle, because the load advances to MEM.
- MC release cycle with a load-use hazard present: the bubble is allowed; mc_done and idex_bubble may coincide.
- ifid_flush and idex_bubble are never asserted while mem_stall_req=1.
- stall_cnt increments each cycle with pc_en=0 and holds at all-ones.

Test Plan:
- Reset mid-operation: rst pulse while in MC with mc_cnt=1 -> immediately mc_busy=0, ex_hold=0, stall_cnt=0; after release, pc_en=1.
- Load-use: ex_memread=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> one cycle of pc_en=0, ifid_en=0, idex_bubble=1; ex_rd=0 with id_rs1=0 -> no bubble.
- Multi-cycle op, MC_LAT=4: ex_multicycle pulse -> ex_hold high for exactly 3 cycles; mc_done pulses in the 4th cycle with ex_hold=0; stall_cnt=3.
- Mem stall during MC, MC_LAT=4: mem_stall_req high 2 cycles in the 2nd hold cycle -> mc_cnt frozen; hold extends to 5 cycles; mc_done still single-pulse.
- Branch vs load-use same cycle: ex_branch_taken=1 with load-use condition true -> ifid_flush=1, idex_bubble=1, pc_en=1.
- Branch under mem stall: ex_branch_taken=1 with mem_stall_req=1 -> ifid_flush=0, pc_en=0; flush occurs in the cycle mem_stall_req drops.
- Saturation: CNT_W=4, 20 consecutive stall cycles -> stall_cnt=15.
